oq_stats_accum: RTL and testbench
=================================

// Module: oq_stats_accum
// PURPOSE
//  Parametrised per-queue statistics front end for the DRAM output queues.
//  - Collects multi-bit per-cycle event increments (words in/out, shortcut words, DRAM rd/wr words) into narrow saturating accumulators.
//  - Flushes them on a fixed cadence into the generic_regs counter_updates bus.
//  - Tracks packets-in-queue occupancy with high watermark, saturation and underflow detection.
//  - Sits between the queue datapath and the register block, replacing ad-hoc per-signal accumulation.
// PARAMETERS
//  NUM_QUEUES      8   number of output queues
//  NUM_EVENTS      5   event types per queue
//  EVENT_WIDTH     2   width of each per-cycle increment (0..2^EVENT_WIDTH-1)
//  ACC_WIDTH       4   accumulator/update width; matches generic_regs COUNTER_INPUT_WIDTH
//  FLUSH_INTERVAL  8   cycles between flushes; power of two, >=2; matches MIN_UPDATE_INTERVAL
//  OCC_WIDTH       32  occupancy/watermark counter width
// PORTS
//  clk              in   1                                 clock
//  reset_n          in   1                                 async active-low reset
//  event_incr       in   NUM_QUEUES*NUM_EVENTS*EVENT_WIDTH  increments; lane index = q*NUM_EVENTS+e
//  pkt_stored       in   NUM_QUEUES                        one packet enqueued this cycle
//  pkt_removed      in   NUM_QUEUES                        one packet dequeued this cycle
//  wm_clear         in   NUM_QUEUES                        pulse: reload watermark from occupancy
//  flag_clear       in   NUM_QUEUES                        pulse: clear that queue's sticky flags
//  counter_updates  out  NUM_EVENTS*NUM_QUEUES*ACC_WIDTH   flushed values, event-major: slice e*NUM_QUEUES+q
//  update_valid     out  1                                 high on the flush-output cycle
//  pkts_in_q        out  NUM_QUEUES*OCC_WIDTH              current occupancy
//  pkts_in_q_max    out  NUM_QUEUES*OCC_WIDTH              high watermark
//  acc_ovf          out  NUM_QUEUES*NUM_EVENTS             sticky: accumulator saturated
//  occ_err          out  2*NUM_QUEUES                      sticky {overflow[q], underflow[q]} per queue
// BEHAVIOUR
//  Reset (reset_n low, async): all outputs, accumulators, and phase cleared to 0. Re-entry mid-interval discards partial sums.
//  phase: log2(FLUSH_INTERVAL)-bit counter, wraps FLUSH_INTERVAL-1 -> 0.
//  Accumulator lane: sum = acc + event_incr, clamped to 2^ACC_WIDTH-1.
//    - Clamp sets acc_ovf for that lane.
//    - phase==FLUSH_INTERVAL-1: counter_updates lane <= sum; acc <= 0; update_valid <= 1.
//    - Otherwise: acc <= sum; counter_updates <= 0; update_valid <= 0.
//    - Result: nonzero updates exactly once per FLUSH_INTERVAL cycles, 1-cycle latency after the flush phase, zeros elsewhere.
//    - Increments arriving on the flush cycle land in the flushed value, never lost.
//  Occupancy per queue, registered, 1-cycle latency:
//    - stored&removed: unchanged.
//    - stored only: +1; at 2^OCC_WIDTH-1, holds and sets overflow flag.
//    - removed only: -1; at 0, holds 0 and sets underflow flag.
//  Watermark:
//    - max <= occ_next when occ_next > max.
//    - wm_clear: max <= occ_next, taking the same-cycle update into account.
//  Sticky flags:
//    - flag_clear clears them.
//    - A set and a clear in the same cycle: set wins.
//  No state machine beyond phase. No backpressure: consumer must accept every update_valid cycle.
// STRUCTURE
//  Shared defines header holds:
//    - OQ_STATS event indices (INPUT_WORDS=0, OUTPUT_WORDS=1, SHORTCUT_WORDS=2, DRAM_WR_WORDS=3, DRAM_RD_WORDS=4).
//    - log2 helper function.
//  Sub-module oq_stats_sat_acc:
//    - One saturating accumulator lane: acc, sum, flush, and ovf flag.
//    - generate-instantiated NUM_QUEUES*NUM_EVENTS times.
//  Occupancy/watermark logic stays inline, one generate loop over queues.
// TESTING
//  1. Defaults, event_incr lane(q=2,e=1)=1 every cycle from reset -> update slice(e=1,q=2) = 8 each flush, update_valid period 8, zeros between.
//  2. Lane incr=3 for 8 cycles (sum 24 > 15) -> flushed value 15, acc_ovf bit 2*5+1... of that lane set. flag_clear on its queue -> cleared; set+clear same cycle -> stays set.
//  3. Incr=1 only on the flush-phase cycle -> value 1 appears next cycle; following interval flushes 0.
//  4. Queue 0 occupancy:
//     - stored x5, then removed x2 -> pkts_in_q=3, max=5.
//     - stored&removed together -> 3.
//     - wm_clear -> max=3.
//  5. Queue 0 occupancy limits:
//     - removed at occupancy 0 -> stays 0, underflow flag set.
//     - OCC_WIDTH=4, stored x16 -> holds 15, overflow flag set.
//  6. Assert reset_n low mid-interval with nonzero accumulators -> all outputs 0 immediately. After release, first update_valid comes 8 cycles later with only post-reset sums.

Source files
------------

// File: rtl/oq_stats_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oq_stats_accum_pkg
// Brief    : Shared event indices and helpers for the output-queue statistics
// Revision : 1.0 - initial release
// ============================================================================
package oq_stats_accum_pkg;

    localparam int c_OQ_STATS_NUM_EVENTS = 5;

    typedef enum logic [2:0] {
        OQ_STATS_INPUT_WORDS    = 3'd0,
        OQ_STATS_OUTPUT_WORDS   = 3'd1,
        OQ_STATS_SHORTCUT_WORDS = 3'd2,
        OQ_STATS_DRAM_WR_WORDS  = 3'd3,
        OQ_STATS_DRAM_RD_WORDS  = 3'd4
    } oq_stats_event_e;

    // Ceiling log2; returns at least 1 so a counter of this width is never empty.
    function automatic int log2_ceil(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oq_stats_sat_acc.sv
`default_nettype none
// ============================================================================
// Module   : oq_stats_sat_acc
// Brief    : One saturating statistics accumulator lane with flush and
//            sticky saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module oq_stats_sat_acc
    import oq_stats_accum_pkg::*;
#(
    parameter int EVENT_WIDTH = 2,
    parameter int ACC_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_flush,
    input  logic [EVENT_WIDTH-1:0] i_incr,
    input  logic                   i_ovf_clear,
    output logic [ACC_WIDTH-1:0]   o_update,
    output logic                   o_ovf
);

    localparam int c_SUM_W = ((ACC_WIDTH > EVENT_WIDTH) ? ACC_WIDTH : EVENT_WIDTH) + 1;
    localparam logic [c_SUM_W-1:0] c_ACC_MAX = c_SUM_W'({ACC_WIDTH{1'b1}});

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_update;
    logic                 r_ovf;
    logic [c_SUM_W-1:0]   w_sum_raw;
    logic                 w_sat;
    logic [ACC_WIDTH-1:0] w_sum;

    assign w_sum_raw = c_SUM_W'(r_acc) + c_SUM_W'(i_incr);
    assign w_sat     = (w_sum_raw > c_ACC_MAX);
    assign w_sum     = w_sat ? {ACC_WIDTH{1'b1}} : w_sum_raw[ACC_WIDTH-1:0];

    // The flush cycle's own increment is folded into the flushed value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_update <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (i_flush) begin
                r_update <= w_sum;
                r_acc    <= '0;
            end else begin
                r_update <= '0;
                r_acc    <= w_sum;
            end
            r_ovf <= w_sat | (r_ovf & ~i_ovf_clear);
        end
    end

    assign o_update = r_update;
    assign o_ovf    = r_ovf;

endmodule
`default_nettype wire

// File: rtl/oq_stats_accum.sv
`default_nettype none
// ============================================================================
// Module   : oq_stats_accum
// Brief    : Per-queue statistics front end: saturating event accumulators
//            flushed on a fixed cadence, plus occupancy/watermark tracking
// Revision : 1.0 - initial release
// ============================================================================
module oq_stats_accum
    import oq_stats_accum_pkg::*;
#(
    parameter int NUM_QUEUES     = 8,
    parameter int NUM_EVENTS     = c_OQ_STATS_NUM_EVENTS,
    parameter int EVENT_WIDTH    = 2,
    parameter int ACC_WIDTH      = 4,
    parameter int FLUSH_INTERVAL = 8,
    parameter int OCC_WIDTH      = 32
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [NUM_QUEUES*NUM_EVENTS*EVENT_WIDTH-1:0] event_incr,
    input  logic [NUM_QUEUES-1:0]                      pkt_stored,
    input  logic [NUM_QUEUES-1:0]                      pkt_removed,
    input  logic [NUM_QUEUES-1:0]                      wm_clear,
    input  logic [NUM_QUEUES-1:0]                      flag_clear,
    output logic [NUM_EVENTS*NUM_QUEUES*ACC_WIDTH-1:0] counter_updates,
    output logic                                       update_valid,
    output logic [NUM_QUEUES*OCC_WIDTH-1:0]            pkts_in_q,
    output logic [NUM_QUEUES*OCC_WIDTH-1:0]            pkts_in_q_max,
    output logic [NUM_QUEUES*NUM_EVENTS-1:0]           acc_ovf,
    output logic [2*NUM_QUEUES-1:0]                    occ_err
);

    localparam int c_PHASE_W = log2_ceil(FLUSH_INTERVAL);
    localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(FLUSH_INTERVAL - 1);

    logic [c_PHASE_W-1:0] r_phase;
    logic                 r_update_valid;
    logic                 w_flush;

    assign w_flush = (r_phase == c_PHASE_LAST);

    // Interval length is a power of two, so the phase wraps on its own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase        <= '0;
            r_update_valid <= 1'b0;
        end else begin
            r_phase        <= r_phase + c_PHASE_W'(1);
            r_update_valid <= w_flush;
        end
    end

    assign update_valid = r_update_valid;

    // Inputs are queue-major, the update bus is event-major.
    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_event
            oq_stats_sat_acc #(
                .EVENT_WIDTH (EVENT_WIDTH),
                .ACC_WIDTH   (ACC_WIDTH)
            ) u_lane (
                .clk         (clk),
                .reset_n     (reset_n),
                .i_flush     (w_flush),
                .i_incr      (event_incr[(q*NUM_EVENTS+e)*EVENT_WIDTH +: EVENT_WIDTH]),
                .i_ovf_clear (flag_clear[q]),
                .o_update    (counter_updates[(e*NUM_QUEUES+q)*ACC_WIDTH +: ACC_WIDTH]),
                .o_ovf       (acc_ovf[q*NUM_EVENTS+e])
            );
        end
    end

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_occ
        localparam logic [OCC_WIDTH-1:0] c_OCC_MAX = '1;

        logic [OCC_WIDTH-1:0] r_occ;
        logic [OCC_WIDTH-1:0] r_max;
        logic                 r_ovf;
        logic                 r_udf;
        logic [OCC_WIDTH-1:0] w_occ_next;
        logic                 w_ovf_set;
        logic                 w_udf_set;

        always_comb begin
            w_occ_next = r_occ;
            w_ovf_set  = 1'b0;
            w_udf_set  = 1'b0;
            if (pkt_stored[q] && !pkt_removed[q]) begin
                if (r_occ == c_OCC_MAX) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_occ_next = r_occ + OCC_WIDTH'(1);
                end
            end else if (!pkt_stored[q] && pkt_removed[q]) begin
                if (r_occ == '0) begin
                    w_udf_set = 1'b1;
                end else begin
                    w_occ_next = r_occ - OCC_WIDTH'(1);
                end
            end
        end

        // Watermark follows the post-update occupancy, including on reload.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_occ <= '0;
                r_max <= '0;
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                r_occ <= w_occ_next;
                if (wm_clear[q] || (w_occ_next > r_max)) begin
                    r_max <= w_occ_next;
                end
                r_ovf <= w_ovf_set | (r_ovf & ~flag_clear[q]);
                r_udf <= w_udf_set | (r_udf & ~flag_clear[q]);
            end
        end

        assign pkts_in_q[q*OCC_WIDTH +: OCC_WIDTH]     = r_occ;
        assign pkts_in_q_max[q*OCC_WIDTH +: OCC_WIDTH] = r_max;
        assign occ_err[2*q+1]                          = r_ovf;
        assign occ_err[2*q]                            = r_udf;
    end

endmodule
`default_nettype wire

// File: tb/tb_oq_stats_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_oq_stats_accum
// Brief    : Directed bench for oq_stats_accum with a cycle-level reference
//            model and hand-computed spot checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_oq_stats_accum;

    localparam int NQ      = 8;
    localparam int NE      = 5;
    localparam int EW      = 2;
    localparam int AW      = 4;
    localparam int FI      = 8;
    localparam int OW      = 4;
    localparam int ACC_MAX = (1 << AW) - 1;
    localparam int OCC_MAX = (1 << OW) - 1;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NQ*NE*EW-1:0]   event_incr;
    logic [NQ-1:0]         pkt_stored;
    logic [NQ-1:0]         pkt_removed;
    logic [NQ-1:0]         wm_clear;
    logic [NQ-1:0]         flag_clear;
    logic [NE*NQ*AW-1:0]   counter_updates;
    logic                  update_valid;
    logic [NQ*OW-1:0]      pkts_in_q;
    logic [NQ*OW-1:0]      pkts_in_q_max;
    logic [NQ*NE-1:0]      acc_ovf;
    logic [2*NQ-1:0]       occ_err;

    always #5 clk = ~clk;

    oq_stats_accum #(
        .NUM_QUEUES     (NQ),
        .NUM_EVENTS     (NE),
        .EVENT_WIDTH    (EW),
        .ACC_WIDTH      (AW),
        .FLUSH_INTERVAL (FI),
        .OCC_WIDTH      (OW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .event_incr      (event_incr),
        .pkt_stored      (pkt_stored),
        .pkt_removed     (pkt_removed),
        .wm_clear        (wm_clear),
        .flag_clear      (flag_clear),
        .counter_updates (counter_updates),
        .update_valid    (update_valid),
        .pkts_in_q       (pkts_in_q),
        .pkts_in_q_max   (pkts_in_q_max),
        .acc_ovf         (acc_ovf),
        .occ_err         (occ_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: cycles since reset decide the flush, sums are plain ints.
    int m_acc  [NQ][NE];
    int m_upd  [NQ][NE];
    bit m_aovf [NQ][NE];
    bit m_valid;
    int m_cycle;
    int m_occ  [NQ];
    int m_max  [NQ];
    bit m_oovf [NQ];
    bit m_udf  [NQ];

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            for (int e = 0; e < NE; e++) begin
                m_acc[q][e] = 0; m_upd[q][e] = 0; m_aovf[q][e] = 1'b0;
            end
            m_occ[q] = 0; m_max[q] = 0; m_oovf[q] = 1'b0; m_udf[q] = 1'b0;
        end
        m_valid = 1'b0;
        m_cycle = 0;
    endtask

    task automatic model_step();
        bit flush;
        int s;
        int nxt;
        bit oset;
        bit uset;
        flush = ((m_cycle % FI) == FI - 1);
        for (int q = 0; q < NQ; q++) begin
            for (int e = 0; e < NE; e++) begin
                s = m_acc[q][e] + int'(event_incr[(q*NE+e)*EW +: EW]);
                if (s > ACC_MAX) begin
                    s = ACC_MAX;
                    m_aovf[q][e] = 1'b1;
                end else if (flag_clear[q]) begin
                    m_aovf[q][e] = 1'b0;
                end
                m_upd[q][e] = flush ? s : 0;
                m_acc[q][e] = flush ? 0 : s;
            end
            nxt = m_occ[q]; oset = 1'b0; uset = 1'b0;
            if (pkt_stored[q] && !pkt_removed[q]) begin
                if (m_occ[q] == OCC_MAX) oset = 1'b1; else nxt = m_occ[q] + 1;
            end else if (pkt_removed[q] && !pkt_stored[q]) begin
                if (m_occ[q] == 0) uset = 1'b1; else nxt = m_occ[q] - 1;
            end
            m_occ[q] = nxt;
            if (wm_clear[q] || nxt > m_max[q]) m_max[q] = nxt;
            m_oovf[q] = oset || (m_oovf[q] && !flag_clear[q]);
            m_udf[q]  = uset || (m_udf[q] && !flag_clear[q]);
        end
        m_valid = flush;
        m_cycle++;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    logic [NE*NQ*AW-1:0] e_upd;
    logic [NQ*NE-1:0]    e_aovf;
    logic [NQ*OW-1:0]    e_occ;
    logic [NQ*OW-1:0]    e_max;
    logic [2*NQ-1:0]     e_err;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int q = 0; q < NQ; q++) begin
                for (int e = 0; e < NE; e++) begin
                    e_upd[(e*NQ+q)*AW +: AW] = AW'(m_upd[q][e]);
                    e_aovf[q*NE+e]           = m_aovf[q][e];
                end
                e_occ[q*OW +: OW] = OW'(m_occ[q]);
                e_max[q*OW +: OW] = OW'(m_max[q]);
                e_err[2*q+1]      = m_oovf[q];
                e_err[2*q]        = m_udf[q];
            end
            check("model_update_valid", 160'(update_valid), 160'(m_valid));
            check("model_counter_updates", 160'(counter_updates), 160'(e_upd));
            check("model_acc_ovf", 160'(acc_ovf), 160'(e_aovf));
            check("model_pkts_in_q", 160'(pkts_in_q), 160'(e_occ));
            check("model_pkts_in_q_max", 160'(pkts_in_q_max), 160'(e_max));
            check("model_occ_err", 160'(occ_err), 160'(e_err));
        end
    end

    function automatic int upd_slice(input int e, input int q);
        return int'(counter_updates[(e*NQ+q)*AW +: AW]);
    endfunction

    function automatic int occ_of(input int q);
        return int'(pkts_in_q[q*OW +: OW]);
    endfunction

    function automatic int max_of(input int q);
        return int'(pkts_in_q_max[q*OW +: OW]);
    endfunction

    task automatic set_incr(input int q, input int e, input int v);
        event_incr[(q*NE+e)*EW +: EW] = EW'(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for the next flush output; reports the cycles it took.
    task automatic wait_valid(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 2*FI; i++) begin
            @(negedge clk);
            cycles = i + 1;
            if (update_valid) break;
        end
        if (!update_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no update_valid within %0d cycles", name, 2*FI);
        end
    endtask

    initial begin
        int cyc;
        reset_n     = 1'b0;
        event_incr  = '0;
        pkt_stored  = '0;
        pkt_removed = '0;
        wm_clear    = '0;
        flag_clear  = '0;
        step(2);
        cmp_en = 1'b1;
        check("reset_update_valid", 160'(update_valid), 160'(0));
        check("reset_occ", 160'(pkts_in_q), 160'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Constant 1 on lane (q=2,e=1): every flush carries 8, period 8.
        set_incr(2, 1, 1);
        for (int k = 0; k < 3; k++) begin
            wait_valid("t1_wait", cyc);
            check("t1_period", 160'(cyc), 160'(8));
            check("t1_flush_value", 160'(upd_slice(1, 2)), 160'(8));
        end

        // Saturation: 8 x 3 = 24 clamps to 15, sticky flag on bit 11.
        set_incr(2, 1, 3);
        step(8);
        check("t2_sat_value", 160'(upd_slice(1, 2)), 160'(15));
        check("t2_ovf_set", 160'(acc_ovf[11]), 160'(1));
        set_incr(2, 1, 0);
        flag_clear[2] = 1'b1;
        step(1);
        flag_clear[2] = 1'b0;
        check("t2_ovf_cleared", 160'(acc_ovf[11]), 160'(0));
        set_incr(2, 1, 3);
        step(5);
        flag_clear[2] = 1'b1;
        step(1);
        flag_clear[2] = 1'b0;
        set_incr(2, 1, 0);
        check("t2_set_beats_clear", 160'(acc_ovf[11]), 160'(1));
        step(1);

        // Increment only on the flush-phase cycle lands in that flush.
        step(7);
        set_incr(2, 1, 1);
        step(1);
        set_incr(2, 1, 0);
        check("t3_valid", 160'(update_valid), 160'(1));
        check("t3_late_incr", 160'(upd_slice(1, 2)), 160'(1));
        step(8);
        check("t3_next_valid", 160'(update_valid), 160'(1));
        check("t3_next_zero", 160'(upd_slice(1, 2)), 160'(0));

        // Queue 0 occupancy and watermark.
        pkt_stored[0] = 1'b1;
        step(5);
        pkt_stored[0]  = 1'b0;
        pkt_removed[0] = 1'b1;
        step(2);
        pkt_removed[0] = 1'b0;
        check("t4_occ3", 160'(occ_of(0)), 160'(3));
        check("t4_max5", 160'(max_of(0)), 160'(5));
        pkt_stored[0]  = 1'b1;
        pkt_removed[0] = 1'b1;
        step(1);
        pkt_stored[0]  = 1'b0;
        pkt_removed[0] = 1'b0;
        check("t4_both", 160'(occ_of(0)), 160'(3));
        wm_clear[0] = 1'b1;
        step(1);
        wm_clear[0] = 1'b0;
        check("t4_wm_clear", 160'(max_of(0)), 160'(3));

        // Occupancy limits: underflow at 0, overflow at 15.
        pkt_removed[0] = 1'b1;
        step(4);
        pkt_removed[0] = 1'b0;
        check("t5_udf_occ", 160'(occ_of(0)), 160'(0));
        check("t5_udf_flag", 160'(occ_err[0]), 160'(1));
        pkt_stored[0] = 1'b1;
        step(16);
        pkt_stored[0] = 1'b0;
        check("t5_ovf_occ", 160'(occ_of(0)), 160'(15));
        check("t5_ovf_flag", 160'(occ_err[1]), 160'(1));
        check("t5_ovf_max", 160'(max_of(0)), 160'(15));

        // Mid-interval reset discards partial sums and restarts the cadence.
        set_incr(0, 0, 1);
        set_incr(7, 4, 1);
        step(3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 160'(update_valid), 160'(0));
        check("t6_rst_updates", 160'(counter_updates), 160'(0));
        check("t6_rst_occ", 160'(pkts_in_q), 160'(0));
        check("t6_rst_max", 160'(pkts_in_q_max), 160'(0));
        check("t6_rst_accovf", 160'(acc_ovf), 160'(0));
        check("t6_rst_occerr", 160'(occ_err), 160'(0));
        step(2);
        reset_n = 1'b1;
        step(7);
        check("t6_no_early_valid", 160'(update_valid), 160'(0));
        step(1);
        check("t6_first_valid", 160'(update_valid), 160'(1));
        check("t6_lane00", 160'(upd_slice(0, 0)), 160'(8));
        check("t6_lane74", 160'(upd_slice(4, 7)), 160'(8));
        event_incr = '0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
